// File: rtl/muldiv_hilo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_hilo_ctrl_pkg
// Description : Shared definitions for the HI/LO sequencer. Includes the op
//               encodings, the division iteration count, the FSM state codes
//               and small helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_hilo_ctrl_pkg;

    // Radix-2 iterations needed for 32-bit operands
    localparam int DIV_CYCLES_DFLT = 32;

    // EX-stage HI/LO op encodings
    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    // Controller state codes
    localparam int         ST_W    = 2;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // True for the two ops that use the iterative divider
    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Two's-complement negate when neg is set
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage : muldiv_hilo_ctrl_pkg
`default_nettype wire

// File: rtl/muldiv_hilo_ctrl_div_radix2.sv
`default_nettype none
// ============================================================================
// Module      : div_radix2
// Description : Unsigned restoring divider, one quotient bit per step. The
//               result outputs carry the value *after* the current step, so
//               on the final step the caller can capture the finished
//               quotient/remainder in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module div_radix2 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5,
    parameter int LAST  = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             step,
    input  logic [CNT_W-1:0] cnt,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;

    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_fit;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. A zero divisor always
    // "fits", which yields an all-ones quotient and remainder = dividend.
    always_comb begin
        w_trial   = {rem_q, quo_q[WIDTH-1]};
        w_diff    = w_trial - {1'b0, dvs_q};
        w_fit     = ~w_diff[WIDTH];
        remainder = w_fit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
        quotient  = {quo_q[WIDTH-2:0], w_fit};
        done      = step && (cnt == CNT_W'(LAST));
    end

    // Load operands on start, advance one bit per step
    always_comb begin
        quo_d = quo_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        if (start) begin
            quo_d = dividend;
            rem_d = '0;
            dvs_d = divisor;
        end else if (step) begin
            quo_d = quotient;
            rem_d = remainder;
        end
    end

    // Divider working registers
    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
        end
    end

endmodule : div_radix2
`default_nettype wire

// File: rtl/muldiv_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_hilo_ctrl
// Description : HI/LO sequencer and sole HI/LO write-port owner. It handles
//               single-cycle MULT/MULTU/MTHI/MTLO and 32-step iterative
//               DIV/DIVU with a pipeline stall. There is exactly one write per
//               instruction, and a flush cancels it.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_hilo_ctrl
    import muldiv_hilo_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DFLT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall_o,
    output logic        busy_o,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata
);

    localparam int CNT_W = $clog2(DIV_CYCLES);

    logic [ST_W-1:0]  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             pend_hi_q, pend_hi_d;
    logic             pend_lo_q, pend_lo_d;
    logic [31:0]      pend_hi_data_q, pend_hi_data_d;
    logic [31:0]      pend_lo_data_q, pend_lo_data_d;

    logic             w_accept;
    logic             w_div_start;
    logic             w_signed_div;
    logic             w_signed_mul;
    logic [31:0]      w_dvd_mag;
    logic [31:0]      w_dvs_mag;
    logic [63:0]      w_ext_a;
    logic [63:0]      w_ext_b;
    logic [63:0]      w_product;
    logic             w_step;
    logic [31:0]      w_div_quo;
    logic [31:0]      w_div_rem;
    logic             w_div_done;

    // Operand conditioning: accept decode, divider magnitudes, multiplier.
    // Sign- or zero-extending both factors to 64 bits lets a single
    // 64-bit multiply serve MULT and MULTU.
    always_comb begin
        w_accept     = (state_q == ST_IDLE) && op_valid && !flush;
        w_div_start  = w_accept && is_div_op(op);
        w_signed_div = (op == OP_DIV);
        w_signed_mul = (op == OP_MULT);
        w_dvd_mag    = cond_neg(src_a, w_signed_div && src_a[31]);
        w_dvs_mag    = cond_neg(src_b, w_signed_div && src_b[31]);
        w_ext_a      = {{32{w_signed_mul && src_a[31]}}, src_a};
        w_ext_b      = {{32{w_signed_mul && src_b[31]}}, src_b};
        w_product    = w_ext_a * w_ext_b;
        w_step       = (state_q == ST_RUN) && !flush;
    end

    div_radix2 #(
        .WIDTH (32),
        .CNT_W (CNT_W),
        .LAST  (DIV_CYCLES - 1)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (w_div_start),
        .dividend  (w_dvd_mag),
        .divisor   (w_dvs_mag),
        .step      (w_step),
        .cnt       (cnt_q),
        .quotient  (w_div_quo),
        .remainder (w_div_rem),
        .done      (w_div_done)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: flush always returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_div_start) state_d = ST_RUN;
            ST_RUN:  if (w_div_done)  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    // FSM outputs: stall covers the accept cycle combinationally plus RUN
    always_comb begin
        stall_o  = (state_q == ST_RUN) || w_div_start;
        busy_o   = (state_q != ST_IDLE);
        hi_we    = pend_hi_q && !flush;
        lo_we    = pend_lo_q && !flush;
        hi_wdata = pend_hi_data_q;
        lo_wdata = pend_lo_data_q;
    end

    // Datapath next values: counter, sign flags and the pending write.
    // Pending enables are one-shot; they default to clear every cycle.
    always_comb begin
        cnt_d          = cnt_q;
        neg_quo_d      = neg_quo_q;
        neg_rem_d      = neg_rem_q;
        pend_hi_d      = 1'b0;
        pend_lo_d      = 1'b0;
        pend_hi_data_d = pend_hi_data_q;
        pend_lo_data_d = pend_lo_data_q;
        if (flush) begin
            cnt_d = '0;
        end else begin
            if (w_accept) begin
                case (op)
                    OP_MULT, OP_MULTU: begin
                        pend_hi_d      = 1'b1;
                        pend_lo_d      = 1'b1;
                        pend_hi_data_d = w_product[63:32];
                        pend_lo_data_d = w_product[31:0];
                    end
                    OP_MTHI: begin
                        pend_hi_d      = 1'b1;
                        pend_hi_data_d = src_a;
                    end
                    OP_MTLO: begin
                        pend_lo_d      = 1'b1;
                        pend_lo_data_d = src_a;
                    end
                    OP_DIV, OP_DIVU: begin
                        cnt_d     = '0;
                        neg_quo_d = w_signed_div && (src_a[31] ^ src_b[31]);
                        neg_rem_d = w_signed_div && src_a[31];
                    end
                    default: begin
                        cnt_d = cnt_q;
                    end
                endcase
            end
            if (state_q == ST_RUN) begin
                if (w_div_done) begin
                    pend_hi_d      = 1'b1;
                    pend_lo_d      = 1'b1;
                    pend_hi_data_d = cond_neg(w_div_rem, neg_rem_q);
                    pend_lo_data_d = cond_neg(w_div_quo, neg_quo_q);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            neg_quo_q      <= 1'b0;
            neg_rem_q      <= 1'b0;
            pend_hi_q      <= 1'b0;
            pend_lo_q      <= 1'b0;
            pend_hi_data_q <= '0;
            pend_lo_data_q <= '0;
        end else begin
            cnt_q          <= cnt_d;
            neg_quo_q      <= neg_quo_d;
            neg_rem_q      <= neg_rem_d;
            pend_hi_q      <= pend_hi_d;
            pend_lo_q      <= pend_lo_d;
            pend_hi_data_q <= pend_hi_data_d;
            pend_lo_data_q <= pend_lo_data_d;
        end
    end

endmodule : muldiv_hilo_ctrl
`default_nettype wire
